// File: rtl/ehgu_clkdiv_cfg_ctrl.sv
// ehgu_clkdiv_cfg_ctrl
//
// Configuration sequencer for ehgu_clkdiv_fractional. Each accepted request
// is applied glitch-free: drop en, wait a quiesce window, load the new
// integer/fractional divisor, wait a settle window, then restore en to the
// requested value. The divider ratio is int_div + frac_div/2^FRAC_W.
//
// Optional feature macro: EHGU_CLKDIV_CFG_RANGE_CHECK_EN
//   defined   : an accepted request with req_int_div < MIN_INT_DIV is
//               consumed, answered with a one-cycle cfg_err pulse, and
//               leaves the outputs untouched.
//   undefined : every request runs the full sequence, cfg_err is tied 0.
//
// Handshake: a request transfers on a rising clkin edge where
// req_valid & req_ready are both high; req_ready is high only in IDLE, so a
// held request waits and is taken on the first IDLE edge. Fields and req_en
// are captured at that edge; req_* may change freely afterwards.
//
// Ports:
//   clkin        in   clock (block and divider input clock)
//   rstn         in   asynchronous active-low reset
//   req_valid    in   request present
//   req_ready    out  high only in IDLE (registered)
//   req_int_div  in   requested integer divisor   [INT_W]
//   req_frac_div in   requested fractional divisor [FRAC_W]
//   req_en       in   enable to apply at the end of the sequence
//   int_div      out  integer divisor to divider (registered)
//   frac_div     out  fractional divisor to divider (registered)
//   en           out  divider enable (registered)
//   busy         out  high outside IDLE (registered)
//   cfg_done     out  one-cycle pulse when a sequence completes
//   cfg_err      out  one-cycle pulse when a request is rejected
//   dbg_state    out  current FSM state (0 IDLE, 1 DRAIN, 2 LOAD, 3 SETTLE)

module ehgu_clkdiv_cfg_ctrl #(
  parameter int INT_W          = 8,
  parameter int FRAC_W         = 2,
  parameter int QUIESCE_CYCLES = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int RESET_INT_DIV  = 2,
  parameter int MIN_INT_DIV    = 2
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [INT_W-1:0]  req_int_div,
  input  logic [FRAC_W-1:0] req_frac_div,
  input  logic              req_en,
  output logic [INT_W-1:0]  int_div,
  output logic [FRAC_W-1:0] frac_div,
  output logic              en,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  // One down-counter serves both windows; size it for the longer one.
  localparam int CNT_MAX = (QUIESCE_CYCLES > SETTLE_CYCLES) ? QUIESCE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] QUIESCE_LOAD = CNT_W'(QUIESCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [INT_W-1:0] RESET_DIV    = INT_W'(RESET_INT_DIV);

  // Elaboration-time parameter sanity.
  if (QUIESCE_CYCLES < 1) begin : g_bad_quiesce
    $error("QUIESCE_CYCLES must be >= 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end
  if (MIN_INT_DIV < 0 || MIN_INT_DIV >= (1 << INT_W)) begin : g_bad_min
    $error("MIN_INT_DIV must fit in INT_W bits");
  end

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [INT_W-1:0]    cap_int_div;
  logic [FRAC_W-1:0]   cap_frac_div;
  logic                cap_en;
  logic                accept;
  logic                reject;
  logic                start_seq;
  logic                load_div;
  logic                finish_seq;

  assign accept = req_valid & req_ready;

`ifdef EHGU_CLKDIV_CFG_RANGE_CHECK_EN
  localparam logic [INT_W-1:0] MIN_DIV = INT_W'(MIN_INT_DIV);
  assign reject = (req_int_div < MIN_DIV);
`else
  assign reject = 1'b0;
`endif

  // Next-state and sequencing strobes.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    start_seq  = 1'b0;
    load_div   = 1'b0;
    finish_seq = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept && !reject) begin
          start_seq = 1'b1;
          state_nxt = ST_DRAIN;
          cnt_nxt   = QUIESCE_LOAD;
        end
      end
      ST_DRAIN: begin
        if (cnt == '0) begin
          state_nxt = ST_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_LOAD: begin
        load_div  = 1'b1;
        cnt_nxt   = SETTLE_LOAD;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          finish_seq = 1'b1;
          state_nxt  = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cap_int_div  <= '0;
      cap_frac_div <= '0;
      cap_en       <= 1'b0;
      int_div      <= RESET_DIV;
      frac_div     <= '0;
      en           <= 1'b0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      cfg_done     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      // Handshake flags track the state being entered so they stay registered.
      req_ready <= (state_nxt == ST_IDLE);
      busy      <= (state_nxt != ST_IDLE);
      cfg_done  <= finish_seq;
      if (start_seq) begin
        cap_int_div  <= req_int_div;
        cap_frac_div <= req_frac_div;
        cap_en       <= req_en;
        en           <= 1'b0;
      end
      // en is low throughout DRAIN/LOAD/SETTLE, so the divisor never
      // changes under a running divider.
      if (load_div) begin
        int_div  <= cap_int_div;
        frac_div <= cap_frac_div;
      end
      if (finish_seq) begin
        en <= cap_en;
      end
    end
  end

`ifdef EHGU_CLKDIV_CFG_RANGE_CHECK_EN
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= accept & reject;
    end
  end
`else
  assign cfg_err = 1'b0;
`endif

  assign dbg_state = state;

endmodule

// File: tb/tb_ehgu_clkdiv_cfg_ctrl.sv
// Directed bench for ehgu_clkdiv_cfg_ctrl with default parameters
// (QUIESCE_CYCLES=4, SETTLE_CYCLES=2, RESET_INT_DIV=2). Expected values are
// hand-computed from the edge timeline: accept at E0, divisor loads at E5,
// en/cfg_done at E7. Completed configurations are also checked against an
// expected queue of {int_div, frac_div, en} each time cfg_done is seen.

module tb_ehgu_clkdiv_cfg_ctrl;

  localparam int INT_W  = 8;
  localparam int FRAC_W = 2;
  localparam int CFG_W  = INT_W + FRAC_W + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_LOAD   = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  logic              clkin = 1'b0;
  logic              rstn;
  logic              req_valid;
  logic              req_ready;
  logic [INT_W-1:0]  req_int_div;
  logic [FRAC_W-1:0] req_frac_div;
  logic              req_en;
  logic [INT_W-1:0]  int_div;
  logic [FRAC_W-1:0] frac_div;
  logic              en;
  logic              busy;
  logic              cfg_done;
  logic              cfg_err;
  logic [1:0]        dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [CFG_W-1:0] exp_q[$];

  ehgu_clkdiv_cfg_ctrl dut (
    .clkin        (clkin),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_int_div  (req_int_div),
    .req_frac_div (req_frac_div),
    .req_en       (req_en),
    .int_div      (int_div),
    .frac_div     (frac_div),
    .en           (en),
    .busy         (busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample #1 later; score any completed sequence.
  task automatic step();
    logic [CFG_W-1:0] exp_cfg;
    @(posedge clkin);
    #1;
    if (cfg_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cfg_done", 32'(cfg_done), 32'd0);
      end else begin
        exp_cfg = exp_q.pop_front();
        check("sb_cfg", 32'({int_div, frac_div, en}), 32'(exp_cfg));
      end
    end
  endtask

  task automatic drive_req(input int idiv, input int fdiv, input logic ren);
    req_valid    = 1'b1;
    req_int_div  = INT_W'(idiv);
    req_frac_div = FRAC_W'(fdiv);
    req_en       = ren;
  endtask

  task automatic push_exp(input int idiv, input int fdiv, input logic ren);
    logic [INT_W-1:0]  i_v;
    logic [FRAC_W-1:0] f_v;
    i_v = INT_W'(idiv);
    f_v = FRAC_W'(fdiv);
    exp_q.push_back({i_v, f_v, ren});
  endtask

  initial begin
    rstn         = 1'b1;
    req_valid    = 1'b0;
    req_int_div  = '0;
    req_frac_div = '0;
    req_en       = 1'b0;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clkin);
    #1;

    // Reset state
    check("rst_int_div",  32'(int_div),   32'd2);
    check("rst_frac_div", 32'(frac_div),  32'd0);
    check("rst_en",       32'(en),        32'd0);
    check("rst_ready",    32'(req_ready), 32'd1);
    check("rst_busy",     32'(busy),      32'd0);
    check("rst_done",     32'(cfg_done),  32'd0);
    check("rst_err",      32'(cfg_err),   32'd0);
    check("rst_state",    32'(dbg_state), 32'(S_IDLE));
    @(negedge clkin) rstn = 1'b1;
    step();

    // Normal request 3/1, en=1
    drive_req(3, 1, 1'b1);
    push_exp(3, 1, 1'b1);
    step();                                   // E0
    req_valid = 1'b0;
    check("n_e0_en",    32'(en),        32'd0);
    check("n_e0_busy",  32'(busy),      32'd1);
    check("n_e0_ready", 32'(req_ready), 32'd0);
    check("n_e0_state", 32'(dbg_state), 32'(S_DRAIN));
    repeat (3) step();                        // E1..E3
    check("n_e3_state", 32'(dbg_state), 32'(S_DRAIN));
    step();                                   // E4
    check("n_e4_state", 32'(dbg_state), 32'(S_LOAD));
    check("n_e4_int",   32'(int_div),   32'd2);
    step();                                   // E5
    check("n_e5_int",   32'(int_div),   32'd3);
    check("n_e5_frac",  32'(frac_div),  32'd1);
    check("n_e5_en",    32'(en),        32'd0);
    check("n_e5_state", 32'(dbg_state), 32'(S_SETTLE));
    step();                                   // E6
    check("n_e6_done",  32'(cfg_done),  32'd0);
    check("n_e6_en",    32'(en),        32'd0);
    step();                                   // E7
    check("n_e7_en",    32'(en),        32'd1);
    check("n_e7_done",  32'(cfg_done),  32'd1);
    check("n_e7_ready", 32'(req_ready), 32'd1);
    check("n_e7_busy",  32'(busy),      32'd0);
    step();                                   // E8
    check("n_e8_done",  32'(cfg_done),  32'd0);
    check("n_e8_en",    32'(en),        32'd1);

    // Back-to-back: 6/3 then a held 4/0
    drive_req(6, 3, 1'b1);
    push_exp(6, 3, 1'b1);
    push_exp(4, 0, 1'b1);
    step();                                   // E0
    drive_req(4, 0, 1'b1);
    check("b_e0_busy",  32'(busy), 32'd1);
    repeat (6) step();                        // E1..E6
    check("b_e6_ready", 32'(req_ready), 32'd0);
    check("b_e6_int",   32'(int_div),   32'd6);
    step();                                   // E7
    check("b_e7_done",  32'(cfg_done),  32'd1);
    check("b_e7_frac",  32'(frac_div),  32'd3);
    step();                                   // E8: second accept
    req_valid = 1'b0;
    check("b_e8_en",    32'(en),        32'd0);
    check("b_e8_busy",  32'(busy),      32'd1);
    check("b_e8_done",  32'(cfg_done),  32'd0);
    repeat (6) step();                        // E9..E14
    check("b_e14_done", 32'(cfg_done),  32'd0);
    step();                                   // E15
    check("b_e15_done", 32'(cfg_done),  32'd1);
    check("b_e15_int",  32'(int_div),   32'd4);
    check("b_e15_frac", 32'(frac_div),  32'd0);
    check("b_e15_en",   32'(en),        32'd1);

    // req_en=0: 5/2
    drive_req(5, 2, 1'b0);
    push_exp(5, 2, 1'b0);
    step();                                   // E0
    req_valid = 1'b0;
    repeat (4) step();                        // E1..E4
    check("z_e4_int",   32'(int_div),  32'd4);
    step();                                   // E5
    check("z_e5_int",   32'(int_div),  32'd5);
    check("z_e5_frac",  32'(frac_div), 32'd2);
    step();                                   // E6
    step();                                   // E7
    check("z_e7_done",  32'(cfg_done), 32'd1);
    check("z_e7_en",    32'(en),       32'd0);
    step();

    // Request below MIN_INT_DIV
    drive_req(1, 0, 1'b1);
`ifdef EHGU_CLKDIV_CFG_RANGE_CHECK_EN
    step();                                   // E0
    req_valid = 1'b0;
    check("r_e0_err",   32'(cfg_err),   32'd1);
    check("r_e0_busy",  32'(busy),      32'd0);
    check("r_e0_ready", 32'(req_ready), 32'd1);
    check("r_e0_int",   32'(int_div),   32'd5);
    check("r_e0_en",    32'(en),        32'd0);
    step();                                   // E1
    check("r_e1_err",   32'(cfg_err),   32'd0);
    check("r_e1_busy",  32'(busy),      32'd0);
    check("r_e1_frac",  32'(frac_div),  32'd2);
`else
    push_exp(1, 0, 1'b1);
    step();                                   // E0
    req_valid = 1'b0;
    check("r_e0_err",   32'(cfg_err), 32'd0);
    check("r_e0_busy",  32'(busy),    32'd1);
    repeat (6) step();                        // E1..E6
    step();                                   // E7
    check("r_e7_done",  32'(cfg_done), 32'd1);
    check("r_e7_int",   32'(int_div),  32'd1);
    check("r_e7_en",    32'(en),       32'd1);
    check("r_e7_err",   32'(cfg_err),  32'd0);
    step();
`endif

    // Reset mid-DRAIN
    drive_req(7, 1, 1'b1);
    push_exp(7, 1, 1'b1);
    step();                                   // E0
    req_valid = 1'b0;
    step();                                   // E1
    step();                                   // E2
    check("m_e2_state", 32'(dbg_state), 32'(S_DRAIN));
    #1 rstn = 1'b0;
    #1;
    check("m_rst_int",   32'(int_div),   32'd2);
    check("m_rst_frac",  32'(frac_div),  32'd0);
    check("m_rst_en",    32'(en),        32'd0);
    check("m_rst_ready", 32'(req_ready), 32'd1);
    check("m_rst_busy",  32'(busy),      32'd0);
    check("m_rst_state", 32'(dbg_state), 32'(S_IDLE));
    exp_q.delete();
    repeat (2) step();
    @(negedge clkin) rstn = 1'b1;
    step();
    check("m_post_state", 32'(dbg_state), 32'(S_IDLE));
    drive_req(3, 2, 1'b1);
    push_exp(3, 2, 1'b1);
    step();                                   // E0
    req_valid = 1'b0;
    check("f_e0_busy",  32'(busy), 32'd1);
    repeat (4) step();                        // E1..E4
    step();                                   // E5
    check("f_e5_int",   32'(int_div),  32'd3);
    check("f_e5_frac",  32'(frac_div), 32'd2);
    step();                                   // E6
    step();                                   // E7
    check("f_e7_done",  32'(cfg_done), 32'd1);
    check("f_e7_en",    32'(en),       32'd1);
    step();

    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
